// File: rtl/fdc_pkg.sv
// +----------------------------------------------------------------------+
// | fdc_pkg                                                              |
// | Shared constants and types for the Z80 <-> WD1793 host bridge.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fdc_pkg;

  // Bit positions inside the TR-DOS system register (#FF)
  localparam int FF_SEL_LSB = 0;   // two-bit drive select code
  localparam int FF_RST     = 2;   // controller reset, active low
  localparam int FF_HRDY    = 3;   // head-ready
  localparam int FF_SIDE    = 4;   // side select, inverted on the drive cable

  // Controller ports seen on the CPU address low byte
  localparam logic [7:0] PORT_STATUS = 8'h1F;
  localparam logic [7:0] PORT_DATA   = 8'h7F;

  // Unused low bits of the #FF read-back
  localparam logic [5:0] STATUS_PAD = 6'b111111;

  // Controller register index, taken from a[6:5]
  typedef enum logic [1:0] {
    FDC_REG_CMD    = 2'd0,
    FDC_REG_TRACK  = 2'd1,
    FDC_REG_SECTOR = 2'd2,
    FDC_REG_DATA   = 2'd3
  } fdc_reg_e;

endpackage

`default_nettype wire

// File: rtl/fdc_sync_edge.sv
// +----------------------------------------------------------------------+
// | fdc_sync_edge                                                        |
// | Multi-stage synchroniser for an asynchronous flag with registered    |
// | level and rising-edge outputs.                                       |
// | Ports: clk, reset_n (sync, active low), din (async in),              |
// |        level (synchronised level), rise (one-cycle rising edge)      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fdc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      // Asserted on the same edge that the last stage goes high
      rise  <= chain[STAGES-2] & ~chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fdc_host_bridge.sv
// +----------------------------------------------------------------------+
// | fdc_host_bridge                                                      |
// | Z80-side bridge to a WD1793-compatible core: TR-DOS #FF register,    |
// | edge-detected write strobes, DRQ/INTRQ read-acknowledge flags and an |
// | optional index-counted motor run-on (macro FDC_MOTOR_TIMEOUT_EN).    |
// | Ports: CPU bus (a, d, iorq_n, rd_n, wr_n, cs_n, csff_n, dout, oe_n), |
// |        core side (core_do/drq/intrq/hld, core_wr_*, core_reset_n,    |
// |        core_hrdy, drq_r_dreg, intrq_r_sreg), drive side (fdc_index,  |
// |        fdc_ds, fdc_side1, fdc_motor).                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fdc_host_bridge
  import fdc_pkg::*;
#(
  parameter int DRIVES      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MOTOR_IDX   = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        a,
  input  logic [7:0]        d,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              cs_n,
  input  logic              csff_n,
  output logic [7:0]        dout,
  output logic              oe_n,
  input  logic [7:0]        core_do,
  input  logic              core_drq,
  input  logic              core_intrq,
  input  logic              core_hld,
  output logic              core_wr_stb,
  output logic [1:0]        core_wr_adr,
  output logic [7:0]        core_wr_dat,
  output logic              core_reset_n,
  output logic              core_hrdy,
  output logic              drq_r_dreg,
  output logic              intrq_r_sreg,
  input  logic              fdc_index,
  output logic [DRIVES-1:0] fdc_ds,
  output logic              fdc_side1,
  output logic              fdc_motor
);

  logic [4:0] sysreg;
  logic       ff_wr, ff_wr_q;
  logic       wr, wr_q;
  fdc_reg_e   wr_adr;
  logic       drq_s, intrq_s;
  logic       unused_drq_rise, unused_intrq_rise;
  logic       drq_set, intrq_set;

  assign ff_wr = ~csff_n & ~wr_n & ~iorq_n;
  assign wr    = ~cs_n   & ~wr_n & ~iorq_n;

  // Edge-detect registers reset high so a write already in progress when
  // reset is released is ignored rather than taken as a new bus cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sysreg      <= '0;
      ff_wr_q     <= 1'b1;
      wr_q        <= 1'b1;
      core_wr_stb <= 1'b0;
      wr_adr      <= FDC_REG_CMD;
      core_wr_dat <= '0;
    end else begin
      ff_wr_q     <= ff_wr;
      wr_q        <= wr;
      core_wr_stb <= wr & ~wr_q;
      if (ff_wr & ~ff_wr_q) begin
        sysreg <= d[4:0];
      end
      if (wr & ~wr_q) begin
        wr_adr      <= fdc_reg_e'(a[6:5]);
        core_wr_dat <= d;
      end
    end
  end

  assign core_wr_adr  = wr_adr;
  assign core_reset_n = sysreg[FF_RST];
  assign core_hrdy    = sysreg[FF_HRDY];
  assign fdc_side1    = ~sysreg[FF_SIDE];

  // Drive select codes at or above DRIVES leave every select low
  for (genvar i = 0; i < DRIVES; i++) begin : g_ds
    assign fdc_ds[i] = (sysreg[FF_SEL_LSB +: 2] == 2'(i));
  end

  fdc_sync_edge #(.STAGES(SYNC_STAGES)) u_drq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (core_drq),
    .level   (drq_s),
    .rise    (unused_drq_rise)
  );

  fdc_sync_edge #(.STAGES(SYNC_STAGES)) u_intrq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (core_intrq),
    .level   (intrq_s),
    .rise    (unused_intrq_rise)
  );

  assign drq_set   = ~cs_n & (~rd_n | ~wr_n) & (a == PORT_DATA);
  assign intrq_set = ~cs_n & ~rd_n & (a == PORT_STATUS);

  // Clear wins over set; the flags are meaningless while the core is held in reset
  always_ff @(posedge clk) begin
    if (!reset_n || !sysreg[FF_RST]) begin
      drq_r_dreg   <= 1'b0;
      intrq_r_sreg <= 1'b0;
    end else begin
      if (drq_r_dreg & ~drq_s)      drq_r_dreg <= 1'b0;
      else if (drq_set)             drq_r_dreg <= 1'b1;
      if (intrq_r_sreg & ~intrq_s)  intrq_r_sreg <= 1'b0;
      else if (intrq_set)           intrq_r_sreg <= 1'b1;
    end
  end

  always_comb begin
    dout = 8'hFF;
    if (~cs_n & ~rd_n)        dout = core_do;
    else if (~csff_n & ~rd_n) dout = {intrq_s, drq_s, STATUS_PAD};
  end

  assign oe_n = ~(~rd_n & (~cs_n | ~csff_n));

`ifdef FDC_MOTOR_TIMEOUT_EN
  localparam int CNT_W = (MOTOR_IDX > 0) ? $clog2(MOTOR_IDX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MOTOR_IDX);

  logic             unused_index_level;
  logic             index_rise;
  logic             hld_q;
  logic             hold;
  logic [CNT_W-1:0] idx_cnt;

  fdc_sync_edge #(.STAGES(SYNC_STAGES)) u_index_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (fdc_index),
    .level   (unused_index_level),
    .rise    (index_rise)
  );

  // hold stops at MOTOR_IDX, so the counter can never wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hld_q   <= 1'b0;
      hold    <= 1'b0;
      idx_cnt <= '0;
    end else begin
      hld_q <= core_hld;
      if (core_hld & ~hld_q) begin
        hold    <= 1'b0;
        idx_cnt <= '0;
      end else if (~core_hld & hld_q) begin
        hold    <= (MOTOR_IDX != 0);
        idx_cnt <= '0;
      end else if (hold & index_rise) begin
        idx_cnt <= idx_cnt + 1'b1;
        if (idx_cnt + 1'b1 == CNT_LIM) hold <= 1'b0;
      end
    end
  end

  assign fdc_motor = core_hld | hold;
`else
  logic unused_cfg;
  assign unused_cfg = fdc_index ^ (MOTOR_IDX > 255);
  assign fdc_motor  = core_hld;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fdc_host_bridge.sv
// +----------------------------------------------------------------------+
// | tb_fdc_host_bridge                                                   |
// | Self-checking bench: vector table, hand-written corner sequences and |
// | randomized #FF / controller writes against a behavioural model.      |
// | Motor run-on checks are compiled with FDC_MOTOR_TIMEOUT_EN.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fdc_host_bridge;

  localparam int SYNC = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] a = 8'h00, d = 8'h00;
  logic       iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, cs_n = 1'b1, csff_n = 1'b1;
  logic [7:0] core_do = 8'h5A;
  logic       core_drq = 1'b0, core_intrq = 1'b0, core_hld = 1'b0, fdc_index = 1'b0;

  logic [7:0] dout;
  logic       oe_n, core_wr_stb, core_reset_n, core_hrdy, drq_r_dreg, intrq_r_sreg;
  logic [1:0] core_wr_adr;
  logic [7:0] core_wr_dat;
  logic [3:0] fdc_ds;
  logic       fdc_side1, fdc_motor;

  logic [7:0] d2_dout;
  logic       d2_oe_n, d2_stb, d2_rstn, d2_hrdy, d2_drq, d2_intrq, d2_side1, d2_motor;
  logic [1:0] d2_adr;
  logic [7:0] d2_dat;
  logic [1:0] d2_ds;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fdc_host_bridge #(.DRIVES(4), .SYNC_STAGES(SYNC), .MOTOR_IDX(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .a(a), .d(d), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .cs_n(cs_n), .csff_n(csff_n), .dout(dout), .oe_n(oe_n),
    .core_do(core_do), .core_drq(core_drq), .core_intrq(core_intrq),
    .core_hld(core_hld), .core_wr_stb(core_wr_stb), .core_wr_adr(core_wr_adr),
    .core_wr_dat(core_wr_dat), .core_reset_n(core_reset_n), .core_hrdy(core_hrdy),
    .drq_r_dreg(drq_r_dreg), .intrq_r_sreg(intrq_r_sreg), .fdc_index(fdc_index),
    .fdc_ds(fdc_ds), .fdc_side1(fdc_side1), .fdc_motor(fdc_motor)
  );

  fdc_host_bridge #(.DRIVES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .a(a), .d(d), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .cs_n(cs_n), .csff_n(csff_n), .dout(d2_dout), .oe_n(d2_oe_n),
    .core_do(core_do), .core_drq(core_drq), .core_intrq(core_intrq),
    .core_hld(core_hld), .core_wr_stb(d2_stb), .core_wr_adr(d2_adr),
    .core_wr_dat(d2_dat), .core_reset_n(d2_rstn), .core_hrdy(d2_hrdy),
    .drq_r_dreg(d2_drq), .intrq_r_sreg(d2_intrq), .fdc_index(fdc_index),
    .fdc_ds(d2_ds), .fdc_side1(d2_side1), .fdc_motor(d2_motor)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1; csff_n = 1'b1;
  endtask

  // Write held for len clocks; counts strobe pulses and the cycle of the first one
  task automatic io_write(input logic ff, input logic [7:0] addr, input logic [7:0] data,
                          input int len, output int pulses, output int first);
    @(negedge clk);
    a = addr; d = data; iorq_n = 1'b0; wr_n = 1'b0;
    if (ff) csff_n = 1'b0; else cs_n = 1'b0;
    pulses = 0; first = -1;
    for (int i = 0; i < len + 3; i++) begin
      @(posedge clk); #1;
      if (core_wr_stb) begin
        pulses++;
        if (first < 0) first = i + 1;
      end
      if (i == len - 1) bus_idle();
    end
  endtask

  task automatic io_read(input logic ff, input logic [7:0] addr,
                         output logic [7:0] data, output logic oe);
    @(negedge clk);
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    if (ff) csff_n = 1'b0; else cs_n = 1'b0;
    #1; data = dout; oe = oe_n;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic index_pulse();
    @(negedge clk); fdc_index = 1'b1;
    wait_clk(3);
    fdc_index = 1'b0;
    wait_clk(5);
  endtask

  typedef struct {
    logic       ff;
    logic [7:0] addr;
    logic [7:0] data;
    int         len;
    logic [3:0] ds;
    logic [1:0] ds2;
    logic       side1;
    logic       hrdy;
    logic       rstn;
    logic [1:0] adr;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         pulses, first;
    logic [7:0] rdat;
    logic       roe;
    logic [4:0] ff_m;
    logic [7:0] ra, rd;
    int         sel, rlen;
    logic [3:0] exp_ds;
    logic [1:0] exp_ds2;
    logic [1:0] last_adr;
    logic [7:0] last_dat;

    vecs[0] = '{1'b1, 8'hFF, 8'h1E, 1, 4'b0100, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00};
    vecs[1] = '{1'b1, 8'hFF, 8'h07, 2, 4'b1000, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 8'h00};
    vecs[2] = '{1'b0, 8'h3F, 8'h3C, 2, 4'b1000, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 8'h3C};
    vecs[3] = '{1'b1, 8'hFF, 8'h19, 1, 4'b0010, 2'b10, 1'b0, 1'b1, 1'b0, 2'b01, 8'h3C};
    vecs[4] = '{1'b0, 8'h5F, 8'hC3, 1, 4'b0010, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 8'hC3};
    vecs[5] = '{1'b1, 8'hFF, 8'hE4, 3, 4'b0001, 2'b01, 1'b1, 1'b0, 1'b1, 2'b10, 8'hC3};
    vecs[6] = '{1'b0, 8'h1F, 8'h81, 3, 4'b0001, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 8'h81};
    vecs[7] = '{1'b0, 8'h7F, 8'hA5, 6, 4'b0001, 2'b01, 1'b1, 1'b0, 1'b1, 2'b11, 8'hA5};
    vecs[8] = '{1'b1, 8'hFF, 8'h0C, 1, 4'b0001, 2'b01, 1'b1, 1'b1, 1'b1, 2'b11, 8'hA5};

    // ---------------- reset state ----------------
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(1);
    chk("rst_fdc_ds", fdc_ds, 4'b0001);
    chk("rst_fdc_ds_d2", d2_ds, 2'b01);
    chk("rst_side1", fdc_side1, 1'b1);
    chk("rst_core_reset_n", core_reset_n, 1'b0);
    chk("rst_hrdy", core_hrdy, 1'b0);
    chk("rst_stb", core_wr_stb, 1'b0);
    chk("rst_adr", core_wr_adr, 2'b00);
    chk("rst_dat", core_wr_dat, 8'h00);
    chk("rst_flags", {drq_r_dreg, intrq_r_sreg}, 2'b00);
    chk("rst_motor", fdc_motor, 1'b0);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_oe_n", oe_n, 1'b1);

    // ---------------- vector table ----------------
    foreach (vecs[i]) begin
      io_write(vecs[i].ff, vecs[i].addr, vecs[i].data, vecs[i].len, pulses, first);
      chk($sformatf("vec%0d_ds", i), fdc_ds, vecs[i].ds);
      chk($sformatf("vec%0d_ds_d2", i), d2_ds, vecs[i].ds2);
      chk($sformatf("vec%0d_side1", i), fdc_side1, vecs[i].side1);
      chk($sformatf("vec%0d_hrdy", i), core_hrdy, vecs[i].hrdy);
      chk($sformatf("vec%0d_rstn", i), core_reset_n, vecs[i].rstn);
      chk($sformatf("vec%0d_adr", i), core_wr_adr, vecs[i].adr);
      chk($sformatf("vec%0d_dat", i), core_wr_dat, vecs[i].dat);
      chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].ff ? 0 : 1);
      if (!vecs[i].ff) chk($sformatf("vec%0d_stb_cycle", i), first, 1);
    end

    // ---------------- INTRQ handshake ----------------
    core_intrq = 1'b1;
    wait_clk(SYNC + 2);
    io_read(1'b1, 8'hFF, rdat, roe);
    chk("ff_read_intrq_hi", rdat, 8'hBF);
    chk("ff_read_oe", roe, 1'b0);
    io_read(1'b0, 8'h1F, rdat, roe);
    chk("status_read_dout", rdat, 8'h5A);
    chk("status_read_oe", roe, 1'b0);
    chk("intrq_flag_set", intrq_r_sreg, 1'b1);
    @(negedge clk); core_intrq = 1'b0;
    repeat (SYNC) @(posedge clk);
    #1 chk("intrq_flag_hold", intrq_r_sreg, 1'b1);
    @(posedge clk);
    #1 chk("intrq_flag_clear", intrq_r_sreg, 1'b0);

    // ---------------- DRQ flag and core reset clear ----------------
    core_drq = 1'b1;
    wait_clk(SYNC + 2);
    io_read(1'b0, 8'h7F, rdat, roe);
    wait_clk(2);
    chk("drq_flag_set", drq_r_dreg, 1'b1);
    @(negedge clk);
    a = 8'hFF; d = 8'h00; iorq_n = 1'b0; wr_n = 1'b0; csff_n = 1'b0;
    @(posedge clk); #1;
    chk("ff_clr_core_reset_n", core_reset_n, 1'b0);
    chk("ff_clr_drq_still", drq_r_dreg, 1'b1);
    @(posedge clk); #1;
    chk("ff_clr_drq_cleared", drq_r_dreg, 1'b0);
    bus_idle();
    core_drq = 1'b0;
    wait_clk(SYNC + 2);
    io_read(1'b1, 8'hFF, rdat, roe);
    chk("ff_read_flags_low", rdat, 8'h3F);
    io_write(1'b1, 8'hFF, 8'h0C, 1, pulses, first);

    // ---------------- write held across reset release ----------------
    @(negedge clk);
    reset_n = 1'b0;
    a = 8'h1F; d = 8'h77; iorq_n = 1'b0; wr_n = 1'b0; cs_n = 1'b0;
    wait_clk(2);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (core_wr_stb) pulses++;
    end
    bus_idle();
    wait_clk(2);
    chk("reset_hold_no_stb", pulses, 0);
    chk("reset_hold_dat", core_wr_dat, 8'h00);

    // ---------------- randomized writes vs model ----------------
    ff_m = 5'h00; last_adr = 2'b00; last_dat = 8'h00;
    for (int n = 0; n < 150; n++) begin
      rd   = 8'($urandom);
      rlen = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        ra = 8'hFF;
        io_write(1'b1, ra, rd, rlen, pulses, first);
        ff_m = rd[4:0];
        chk("rnd_ff_pulses", pulses, 0);
      end else begin
        ra = 8'h1F + 8'(32 * $urandom_range(0, 3));
        io_write(1'b0, ra, rd, rlen, pulses, first);
        last_adr = 2'(ra / 32);
        last_dat = rd;
        chk("rnd_cs_pulses", pulses, 1);
      end
      sel     = int'(ff_m % 4);
      exp_ds  = 4'(1 << sel);
      exp_ds2 = (sel < 2) ? 2'(1 << sel) : 2'b00;
      chk("rnd_ds", fdc_ds, exp_ds);
      chk("rnd_ds_d2", d2_ds, exp_ds2);
      chk("rnd_side1", fdc_side1, (ff_m / 16) % 2 == 0);
      chk("rnd_hrdy", core_hrdy, (ff_m / 8) % 2 == 1);
      chk("rnd_rstn", core_reset_n, (ff_m / 4) % 2 == 1);
      chk("rnd_adr", core_wr_adr, last_adr);
      chk("rnd_dat", core_wr_dat, last_dat);
    end

    // ---------------- motor ----------------
`ifdef FDC_MOTOR_TIMEOUT_EN
    @(negedge clk); core_hld = 1'b1;
    wait_clk(3);
    chk("motor_hld_on", fdc_motor, 1'b1);
    core_hld = 1'b0;
    wait_clk(3);
    chk("motor_runon_0", fdc_motor, 1'b1);
    index_pulse();
    chk("motor_runon_1", fdc_motor, 1'b1);
    index_pulse();
    chk("motor_runon_2", fdc_motor, 1'b1);
    index_pulse();
    chk("motor_off_3", fdc_motor, 1'b0);
    @(negedge clk); core_hld = 1'b1;
    wait_clk(3);
    core_hld = 1'b0;
    wait_clk(3);
    index_pulse();
    index_pulse();
    chk("motor_restart_pre", fdc_motor, 1'b1);
    core_hld = 1'b1;
    wait_clk(3);
    chk("motor_restart_hld", fdc_motor, 1'b1);
    core_hld = 1'b0;
    wait_clk(3);
    index_pulse();
    index_pulse();
    chk("motor_restart_2", fdc_motor, 1'b1);
    index_pulse();
    chk("motor_restart_off", fdc_motor, 1'b0);
`else
    @(negedge clk); core_hld = 1'b1;
    #1 chk("motor_follow_on", fdc_motor, 1'b1);
    index_pulse();
    chk("motor_follow_idx", fdc_motor, 1'b1);
    core_hld = 1'b0;
    #1 chk("motor_follow_off", fdc_motor, 1'b0);
    index_pulse();
    chk("motor_follow_idle", fdc_motor, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
